gbt_link_recovery_fsm: RTL and testbench

- Link-recovery sequencer directly upstream of the system clock/reset block.
- Replaces the ad-hoc "no ready for ~2.4 s → pulse" timeout with a deterministic FSM.
- Watches GBT readiness, loss-of-signal (LOS), PLL lock and the PS enable bit; drives the link reset request that feeds the global reset.
- Runs on the 120 MHz MGT reference domain.

---
 rtl/gbt_link_recovery_fsm_pkg.sv | 36 +++
 rtl/gbt_link_recovery_fsm_tick_gen.sv | 51 +++++
 rtl/gbt_link_recovery_fsm.sv | 191 +++++++++++++++++++
 tb/tb_gbt_link_recovery_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gbt_link_recovery_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gbt_link_recovery_fsm_pkg
// Purpose  : Shared types and default constants for the GBT link-recovery
//            sequencer: the 3-bit state encoding (also exported to the PS
//            status register), default timing parameters and a width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gbt_link_recovery_fsm_pkg;

    // Codes are visible to software through state_o; do not renumber.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_HOLD      = 3'd5,
        ST_FAILED    = 3'd6
    } t_gbt_recovery_state;

    localparam int unsigned C_TICK_DIVIDER     = 120000;
    localparam int unsigned C_TIMEOUT_MS       = 2400;
    localparam int unsigned C_LOCK_WAIT_MS     = 100;
    localparam int unsigned C_RST_PULSE_CYCLES = 16;
    localparam int unsigned C_MAX_RETRIES      = 8;
    localparam int unsigned C_DEBOUNCE_CYCLES  = 64;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gbt_link_recovery_fsm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : recovery_tick_gen
// Purpose  : Millisecond timebase for the recovery sequencer. A prescaler
//            produces a one-clock tick every G_TICK_DIVIDER clocks and a
//            saturating counter accumulates ticks. restart_i clears both so
//            every state begins timing from zero.
// Ports    : clk_ik    - clock
//            rstn_ir   - synchronous active-low reset
//            restart_i - clear prescaler and ms counter on this edge
//            tick_o    - high on the last prescaler clock of each period
//            ms_cnt_o  - completed ticks since the last restart
// Revision : 1.0 - initial release
// ============================================================================
module recovery_tick_gen
    import gbt_link_recovery_fsm_pkg::*;
#(
    parameter int unsigned G_TICK_DIVIDER = C_TICK_DIVIDER,
    parameter int unsigned MS_W           = 16
) (
    input  logic            clk_ik,
    input  logic            rstn_ir,
    input  logic            restart_i,
    output logic            tick_o,
    output logic [MS_W-1:0] ms_cnt_o
);

    localparam int unsigned         PRESC_W    = width_for(G_TICK_DIVIDER - 1);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(G_TICK_DIVIDER - 1);

    logic [PRESC_W-1:0] presc;

    assign tick_o = (presc == PRESC_LAST);

    always_ff @(posedge clk_ik) begin
        if (!rstn_ir || restart_i) begin
            presc    <= '0;
            ms_cnt_o <= '0;
        end else if (tick_o) begin
            presc <= '0;
            // Saturate so long dwell states (LINK_UP, FAILED) never wrap.
            if (ms_cnt_o != '1) begin
                ms_cnt_o <= ms_cnt_o + 1'b1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gbt_link_recovery_fsm.sv
`default_nettype none
// ============================================================================
// Module   : gbt_link_recovery_fsm
// Purpose  : Deterministic GBT link-recovery sequencer feeding the global
//            reset block. Pulses link_rst_o, waits for PLL lock and GBT
//            ready with per-state ms timeouts, retries a bounded number of
//            times and parks in FAILED. LOS or PS disable force HOLD.
// Ports    : clk_ik, rstn_ir (sync, active-low)
//            rx_ready_i, tx_ready_i, los_i, pll_locked_i, ps_enable_i
//            link_rst_o, link_up_o, give_up_o, retry_cnt_o[7:0], state_o[2:0]
// Options  : GBT_RECOVERY_DEBOUNCE_EN - filter ready loss in LINK_UP for
//            G_DEBOUNCE_CYCLES consecutive clocks before dropping the link.
// Revision : 1.0 - initial release
// ============================================================================
module gbt_link_recovery_fsm
    import gbt_link_recovery_fsm_pkg::*;
#(
    parameter int unsigned G_TICK_DIVIDER     = C_TICK_DIVIDER,
    parameter int unsigned G_TIMEOUT_MS       = C_TIMEOUT_MS,
    parameter int unsigned G_LOCK_WAIT_MS     = C_LOCK_WAIT_MS,
    parameter int unsigned G_RST_PULSE_CYCLES = C_RST_PULSE_CYCLES,
    parameter int unsigned G_MAX_RETRIES      = C_MAX_RETRIES,
    parameter int unsigned G_DEBOUNCE_CYCLES  = C_DEBOUNCE_CYCLES
) (
    input  logic       clk_ik,
    input  logic       rstn_ir,
    input  logic       rx_ready_i,
    input  logic       tx_ready_i,
    input  logic       los_i,
    input  logic       pll_locked_i,
    input  logic       ps_enable_i,
    output logic       link_rst_o,
    output logic       link_up_o,
    output logic       give_up_o,
    output logic [7:0] retry_cnt_o,
    output logic [2:0] state_o
);

`ifdef GBT_RECOVERY_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    // A one-clock filter is the same as acting on the first low sample.
    localparam int unsigned DEB_CYCLES = (DEB_EN && G_DEBOUNCE_CYCLES > 1) ? G_DEBOUNCE_CYCLES : 1;

    localparam int unsigned MS_MAX = (G_TIMEOUT_MS > G_LOCK_WAIT_MS) ? G_TIMEOUT_MS : G_LOCK_WAIT_MS;
    localparam int unsigned MS_W   = width_for(MS_MAX);
    localparam logic [MS_W-1:0] LINK_LAST = MS_W'(G_TIMEOUT_MS - 1);
    localparam logic [MS_W-1:0] LOCK_LAST = MS_W'(G_LOCK_WAIT_MS - 1);

    localparam int unsigned        PULSE_W    = width_for(G_RST_PULSE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(G_RST_PULSE_CYCLES - 1);

    t_gbt_recovery_state state, state_nxt;
    logic [7:0]          retry_cnt, retry_nxt, retry_inc;
    logic                retry_exhausted;
    logic                ready_q, los_q, pll_locked_q, ps_en_q;
    logic                restart, tick, link_lost, hold_req;
    logic                link_timeout, lock_timeout, pulse_done;
    logic [MS_W-1:0]     ms_cnt;
    logic [PULSE_W-1:0]  pulse_cnt;

    // Single register stage on all inputs; the FSM sees only these.
    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            ready_q      <= 1'b0;
            los_q        <= 1'b0;
            pll_locked_q <= 1'b0;
            ps_en_q      <= 1'b0;
        end else begin
            ready_q      <= rx_ready_i | tx_ready_i;
            los_q        <= los_i;
            pll_locked_q <= pll_locked_i;
            ps_en_q      <= ps_enable_i;
        end
    end

    // Any state change restarts timing, so each state times from its entry.
    assign restart = (state_nxt != state);

    recovery_tick_gen #(
        .G_TICK_DIVIDER (G_TICK_DIVIDER),
        .MS_W           (MS_W)
    ) u_tick_gen (
        .clk_ik    (clk_ik),
        .rstn_ir   (rstn_ir),
        .restart_i (restart),
        .tick_o    (tick),
        .ms_cnt_o  (ms_cnt)
    );

    // Timeout lands on the edge exactly N*G_TICK_DIVIDER clocks after entry.
    assign link_timeout = tick && (ms_cnt == LINK_LAST);
    assign lock_timeout = tick && (ms_cnt == LOCK_LAST);
    assign pulse_done   = (pulse_cnt == PULSE_LAST);

    always_ff @(posedge clk_ik) begin
        if (!rstn_ir || restart || state != ST_RESET) begin
            pulse_cnt <= '0;
        end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    generate
        if (DEB_CYCLES > 1) begin : g_debounce
            localparam int unsigned      DEB_W    = width_for(DEB_CYCLES - 1);
            localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
            logic [DEB_W-1:0] deb_cnt;

            assign link_lost = !ready_q && (deb_cnt == DEB_LAST);

            always_ff @(posedge clk_ik) begin
                if (!rstn_ir || state != ST_LINK_UP || ready_q || link_lost) begin
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end else begin : g_no_debounce
            assign link_lost = !ready_q;
        end
    endgenerate

    assign retry_inc       = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
    assign retry_exhausted = (G_MAX_RETRIES != 0) && (32'(retry_inc) >= G_MAX_RETRIES);
    assign hold_req        = los_q | ~ps_en_q;

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        if (state == ST_IDLE) begin
            state_nxt = ST_RESET;
        end else if (hold_req) begin
            // LOS/disable outranks any timeout on the same edge: no retry counted.
            state_nxt = ST_HOLD;
            if (state == ST_FAILED) begin
                retry_nxt = '0;
            end
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (pulse_done) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (pll_locked_q) begin
                        state_nxt = ST_WAIT_LINK;
                    end else if (lock_timeout) begin
                        retry_nxt = retry_inc;
                        state_nxt = retry_exhausted ? ST_FAILED : ST_RESET;
                    end
                end
                ST_WAIT_LINK: begin
                    // Ready wins over a coincident timeout.
                    if (ready_q) begin
                        state_nxt = ST_LINK_UP;
                        retry_nxt = '0;
                    end else if (link_timeout) begin
                        retry_nxt = retry_inc;
                        state_nxt = retry_exhausted ? ST_FAILED : ST_RESET;
                    end
                end
                ST_LINK_UP: begin
                    if (link_lost) state_nxt = ST_WAIT_LINK;
                end
                ST_HOLD:   state_nxt = ST_RESET;
                ST_FAILED: state_nxt = ST_FAILED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ik) begin
        if (!rstn_ir) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    assign link_rst_o  = (state == ST_RESET) || (state == ST_HOLD) || (state == ST_IDLE);
    assign link_up_o   = (state == ST_LINK_UP);
    assign give_up_o   = (state == ST_FAILED);
    assign retry_cnt_o = retry_cnt;
    assign state_o     = state;

endmodule
`default_nettype wire

// File: tb/tb_gbt_link_recovery_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_gbt_link_recovery_fsm
// Purpose  : Self-checking bench for gbt_link_recovery_fsm. A table of
//            {inputs, hold cycles, expected outputs} rows is walked; each
//            clock pushes the row's expected outputs to a scoreboard queue
//            and pops/compares them one clock later, 1 ns after the edge.
//            Timing uses DIV=10, TIMEOUT=5 ms, LOCK=3 ms, PULSE=4, RETRIES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gbt_link_recovery_fsm;

    localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_WLOCK = 3'd2, S_WLINK = 3'd3,
                           S_UP = 3'd4, S_HOLD = 3'd5, S_FAIL = 3'd6;

    typedef struct {
        logic       rstn, rx, tx, los, pll, ps;
        int         n;
        logic [2:0] st;
        logic       rst, up, give;
        logic [7:0] retry;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic       rst, up, give;
        logic [7:0] retry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn_ir, rx_ready_i, tx_ready_i, los_i, pll_locked_i, ps_enable_i;
    logic       link_rst_o, link_up_o, give_up_o;
    logic [7:0] retry_cnt_o;
    logic [2:0] state_o;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    gbt_link_recovery_fsm #(
        .G_TICK_DIVIDER     (10),
        .G_TIMEOUT_MS       (5),
        .G_LOCK_WAIT_MS     (3),
        .G_RST_PULSE_CYCLES (4),
        .G_MAX_RETRIES      (2),
        .G_DEBOUNCE_CYCLES  (8)
    ) dut (
        .clk_ik       (clk),
        .rstn_ir      (rstn_ir),
        .rx_ready_i   (rx_ready_i),
        .tx_ready_i   (tx_ready_i),
        .los_i        (los_i),
        .pll_locked_i (pll_locked_i),
        .ps_enable_i  (ps_enable_i),
        .link_rst_o   (link_rst_o),
        .link_up_o    (link_up_o),
        .give_up_o    (give_up_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
    );

    function automatic void add(input logic rstn, input logic rx, input logic tx, input logic los,
                                input logic pll, input logic ps, input int n, input logic [2:0] st,
                                input logic rst, input logic up, input logic give, input logic [7:0] retry);
        vec_t v;
        v.rstn = rstn; v.rx = rx; v.tx = tx; v.los = los; v.pll = pll; v.ps = ps; v.n = n;
        v.st = st; v.rst = rst; v.up = up; v.give = give; v.retry = retry;
        vecs.push_back(v);
    endfunction

    task automatic check(input int row, input int cyc);
        exp_t e, a;
        e = sb.pop_front();
        a = {state_o, link_rst_o, link_up_o, give_up_o, retry_cnt_o};
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL row%0d.cyc%0d: got st=%0d rst=%0b up=%0b give=%0b retry=%0d, want st=%0d rst=%0b up=%0b give=%0b retry=%0d",
                     row, cyc, a.st, a.rst, a.up, a.give, a.retry, e.st, e.rst, e.up, e.give, e.retry);
        end
    endtask

    initial begin
        rstn_ir = 1'b0; rx_ready_i = 1'b0; tx_ready_i = 1'b0;
        los_i = 1'b0; pll_locked_i = 1'b0; ps_enable_i = 1'b1;

        //  rstn rx tx los pll ps   n   state   rst up gv retry
        // Reset, then PLL stuck low: WAIT_LOCK times out after 30 clocks.
        add(0, 0, 0, 0, 0, 1,  3, S_IDLE,  1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1,  4, S_RST,   1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 30, S_WLOCK, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1,  4, S_RST,   1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1,  1, S_WLOCK, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  1, S_WLOCK, 0, 0, 0, 1);
        // LOS while waiting for link: HOLD keeps the retry count.
        add(1, 0, 0, 0, 1, 1,  5, S_WLINK, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1,  1, S_WLINK, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1,  9, S_HOLD,  1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  1, S_HOLD,  1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  4, S_RST,   1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  1, S_WLOCK, 0, 0, 0, 1);
        // Ready rises: link_up two edges later, retry cleared.
        add(1, 0, 0, 0, 1, 1,  3, S_WLINK, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 1,  1, S_WLINK, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 1,  5, S_UP,    0, 1, 0, 0);
        // 30-clock LOS in LINK_UP, then 4-clock RESET and re-link.
        add(1, 1, 0, 1, 1, 1,  1, S_UP,    0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 1, 29, S_HOLD,  1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  1, S_HOLD,  1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  4, S_RST,   1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  1, S_WLOCK, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  1, S_WLINK, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  3, S_UP,    0, 1, 0, 0);
`ifdef GBT_RECOVERY_DEBOUNCE_EN
        // 7-clock drop is filtered; 8-clock drop leaves LINK_UP.
        add(1, 0, 0, 0, 1, 1,  7, S_UP,    0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 1,  3, S_UP,    0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1,  8, S_UP,    0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1,  2, S_WLINK, 0, 0, 0, 0);
`else
        // Ready drop leaves immediately; two 50-clock timeouts end in FAILED.
        add(1, 0, 0, 0, 1, 1,  1, S_UP,    0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 50, S_WLINK, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1,  4, S_RST,   1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1,  1, S_WLOCK, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 50, S_WLINK, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 10, S_FAIL,  0, 0, 1, 2);
        // PS enable pulse low: FAILED -> HOLD -> RESET, retry cleared.
        add(1, 0, 0, 0, 1, 0,  1, S_FAIL,  0, 0, 1, 2);
        add(1, 0, 0, 0, 1, 1,  1, S_HOLD,  1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1,  4, S_RST,   1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1,  1, S_WLOCK, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1,  1, S_WLINK, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1,  3, S_UP,    0, 1, 0, 0);
        // Ready coincides with the WAIT_LINK timeout edge: LINK_UP wins.
        add(1, 0, 0, 0, 1, 1,  1, S_UP,    0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 49, S_WLINK, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  1, S_WLINK, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1,  2, S_UP,    0, 1, 0, 0);
        // LOS coincides with the timeout edge: HOLD, no increment.
        add(1, 0, 0, 0, 1, 1,  1, S_UP,    0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 49, S_WLINK, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1,  1, S_WLINK, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1,  3, S_HOLD,  1, 0, 0, 0);
`endif
        // Reset asserted mid-operation returns to IDLE.
        add(0, 0, 0, 0, 1, 1,  2, S_IDLE,  1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                rstn_ir      = vecs[i].rstn;
                rx_ready_i   = vecs[i].rx;
                tx_ready_i   = vecs[i].tx;
                los_i        = vecs[i].los;
                pll_locked_i = vecs[i].pll;
                ps_enable_i  = vecs[i].ps;
                sb.push_back({vecs[i].st, vecs[i].rst, vecs[i].up, vecs[i].give, vecs[i].retry});
                @(posedge clk);
                #1;
                check(i, k);
            end
        end

        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
